// File: rtl/descriptor_chunk_streamer.sv
// Streams one 1280-bit descriptor as 32 indexed 40-bit chunks, followed by a short tail phase,
// with a one-entry pending buffer so the producer can load the next descriptor early.
module descriptor_chunk_streamer #(
    parameter int CHUNK_W     = 40,
    parameter int NUM_CHUNKS  = 32,
    parameter int IDX_W       = 7,
    parameter int TAIL_CYCLES = 2
) (
    input  logic                          iclk,
    input  logic                          irst,
    input  logic                          i_des_valid,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0] i_des,
    input  logic                          i_des_sw,
    output logic                          o_ready,
    input  logic                          i_advance,
    output logic [CHUNK_W-1:0]            o_Des,
    output logic [IDX_W-1:0]              o_des_seq_idx,
    output logic                          o_des_sw,
    output logic                          o_busy,
    output logic [15:0]                   o_frame_cnt
);

    localparam int DES_W  = CHUNK_W * NUM_CHUNKS;
    localparam int TAIL_W = (TAIL_CYCLES > 1) ? $clog2(TAIL_CYCLES) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CHUNKS);
    localparam logic [IDX_W-1:0]  TAIL_IDX  = IDX_W'(NUM_CHUNKS + 1);
    localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        TAIL
    } state_e;

    state_e             state_q,     state_d;
    logic [DES_W-1:0]   pend_q,      pend_d;
    logic               pend_sw_q,   pend_sw_d;
    logic               pend_v_q,    pend_v_d;
    logic [DES_W-1:0]   act_q,       act_d;
    logic               act_sw_q,    act_sw_d;
    logic [IDX_W-1:0]   cnt_q,       cnt_d;
    logic [TAIL_W-1:0]  tail_q,      tail_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    logic handshake;
    logic load;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_sw_d   = pend_sw_q;
        pend_v_d    = pend_v_q;
        act_d       = act_q;
        act_sw_d    = act_sw_q;
        cnt_d       = cnt_q;
        tail_d      = tail_q;
        frame_cnt_d = frame_cnt_q;
        load        = 1'b0;
        handshake   = i_des_valid & ~pend_v_q;

        case (state_q)
            IDLE: begin
                if (pend_v_q && i_advance) load = 1'b1;
            end
            STREAM: begin
                // The shifter stops on the last chunk so the tail keeps presenting it.
                if (cnt_q == LAST_IDX) begin
                    state_d = TAIL;
                    tail_d  = '0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                    act_d = act_q >> CHUNK_W;
                end
            end
            TAIL: begin
                if (tail_q == TAIL_LAST) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    if (pend_v_q && i_advance) load = 1'b1;
                    else                       state_d = IDLE;
                end else begin
                    tail_d = tail_q + TAIL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            act_d    = pend_q;
            act_sw_d = pend_sw_q;
            cnt_d    = IDX_W'(1);
            state_d  = STREAM;
            pend_v_d = 1'b0;
        end

        if (handshake) begin
            pend_d    = i_des;
            pend_sw_d = i_des_sw;
            pend_v_d  = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q     <= IDLE;
            // NOTE: the data buffers are cleared on reset too, so a dropped frame can never resurface.
            pend_q      <= '0;
            pend_sw_q   <= 1'b0;
            pend_v_q    <= 1'b0;
            act_q       <= '0;
            act_sw_q    <= 1'b0;
            cnt_q       <= '0;
            tail_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_sw_q   <= pend_sw_d;
            pend_v_q    <= pend_v_d;
            act_q       <= act_d;
            act_sw_q    <= act_sw_d;
            cnt_q       <= cnt_d;
            tail_q      <= tail_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        o_Des         = '0;
        o_des_seq_idx = '0;
        case (state_q)
            STREAM: begin
                o_Des         = act_q[CHUNK_W-1:0];
                o_des_seq_idx = cnt_q;
            end
            TAIL: begin
                o_Des         = act_q[CHUNK_W-1:0];
                o_des_seq_idx = TAIL_IDX;
            end
            default: ;
        endcase
    end

    assign o_ready     = ~pend_v_q;
    assign o_des_sw    = act_sw_q;
    assign o_busy      = (state_q != IDLE);
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_descriptor_chunk_streamer.sv
// Directed bench for descriptor_chunk_streamer: chunks are scored against a queue filled at load time.
module tb_descriptor_chunk_streamer;

    localparam int CHUNK_W    = 40;
    localparam int NUM_CHUNKS = 32;
    localparam int DES_W      = CHUNK_W * NUM_CHUNKS;

    logic               iclk = 1'b0;
    logic               irst;
    logic               i_des_valid;
    logic [DES_W-1:0]   i_des;
    logic               i_des_sw;
    logic               o_ready;
    logic               i_advance;
    logic [CHUNK_W-1:0] o_Des;
    logic [6:0]         o_des_seq_idx;
    logic               o_des_sw;
    logic               o_busy;
    logic [15:0]        o_frame_cnt;

    descriptor_chunk_streamer dut (
        .iclk          (iclk),
        .irst          (irst),
        .i_des_valid   (i_des_valid),
        .i_des         (i_des),
        .i_des_sw      (i_des_sw),
        .o_ready       (o_ready),
        .i_advance     (i_advance),
        .o_Des         (o_Des),
        .o_des_seq_idx (o_des_seq_idx),
        .o_des_sw      (o_des_sw),
        .o_busy        (o_busy),
        .o_frame_cnt   (o_frame_cnt)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        logic [6:0]         idx;
        logic [CHUNK_W-1:0] chunk;
        logic               sw;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] exp_frames  = 16'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DES_W-1:0] make_des(input logic [7:0] tag, input logic [31:0] pat);
        logic [DES_W-1:0] d;
        d = '0;
        for (int k = 1; k <= NUM_CHUNKS; k++) d[k*CHUNK_W-1 -: CHUNK_W] = {8'(k) ^ tag, pat};
        return d;
    endfunction

    task automatic push_exp(input logic [DES_W-1:0] d, input logic s);
        for (int k = 1; k <= NUM_CHUNKS; k++) begin
            exp_t e;
            e.idx   = 7'(k);
            e.chunk = d[k*CHUNK_W-1 -: CHUNK_W];
            e.sw    = s;
            exp_q.push_back(e);
        end
    endtask

    // Called on a negedge with the pending buffer known empty; returns one negedge later.
    task automatic send(input logic [DES_W-1:0] d, input logic s, input string tag);
        check({tag, "_ready_before_load"}, 64'(o_ready), 64'(1));
        i_des_valid = 1'b1;
        i_des       = d;
        i_des_sw    = s;
        @(negedge iclk);
        i_des_valid = 1'b0;
    endtask

    // Entered on the negedge showing idx=1; leaves on the negedge after the last tail cycle.
    task automatic expect_frame(input logic [DES_W-1:0] d, input logic s, input string tag);
        check({tag, "_idx_first"}, 64'(o_des_seq_idx), 64'(1));
        check({tag, "_busy"}, 64'(o_busy), 64'(1));
        repeat (NUM_CHUNKS - 1) @(negedge iclk);
        check({tag, "_idx_last"}, 64'(o_des_seq_idx), 64'(NUM_CHUNKS));
        @(negedge iclk);
        check({tag, "_idx_tail0"}, 64'(o_des_seq_idx), 64'(NUM_CHUNKS + 1));
        check({tag, "_des_tail"}, 64'(o_Des), 64'(d[DES_W-1 -: CHUNK_W]));
        check({tag, "_sw_tail"}, 64'(o_des_sw), 64'(s));
        @(negedge iclk);
        check({tag, "_idx_tail1"}, 64'(o_des_seq_idx), 64'(NUM_CHUNKS + 1));
        @(negedge iclk);
        exp_frames++;
        check({tag, "_frame_cnt"}, 64'(o_frame_cnt), 64'(exp_frames));
    endtask

    always @(negedge iclk) begin
        if (o_des_seq_idx >= 7'd1 && o_des_seq_idx <= 7'(NUM_CHUNKS)) begin
            check("chunk_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("chunk_idx", 64'(o_des_seq_idx), 64'(e.idx));
                check("chunk_data", 64'(o_Des), 64'(e.chunk));
                check("chunk_sw", 64'(o_des_sw), 64'(e.sw));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DES_W-1:0] des_a, des_a2, des_b, des_c, des_d, des_e, des_f, des_g, des_h;
        des_a  = make_des(8'h00, 32'hA5A5_A5A5);
        des_a2 = make_des(8'h20, 32'h1234_5678);
        des_b  = make_des(8'h40, 32'h9ABC_DEF0);
        des_c  = make_des(8'h60, 32'h0F0F_F0F0);
        des_d  = make_des(8'h80, 32'hDEAD_BEEF);
        des_e  = make_des(8'hA0, 32'hCAFE_F00D);
        des_f  = make_des(8'hC0, 32'h5555_AAAA);
        des_g  = make_des(8'hE0, 32'h3C3C_C3C3);
        des_h  = make_des(8'h11, 32'h7777_0001);

        irst        = 1'b1;
        i_des_valid = 1'b0;
        i_des       = '0;
        i_des_sw    = 1'b0;
        i_advance   = 1'b0;
        repeat (3) @(negedge iclk);
        check("rst_ready", 64'(o_ready), 64'(1));
        check("rst_des", 64'(o_Des), 64'(0));
        check("rst_idx", 64'(o_des_seq_idx), 64'(0));
        check("rst_sw", 64'(o_des_sw), 64'(0));
        check("rst_busy", 64'(o_busy), 64'(0));
        check("rst_frame_cnt", 64'(o_frame_cnt), 64'(0));
        irst = 1'b0;
        @(negedge iclk);

        // T1: single frame, advance high.
        i_advance = 1'b1;
        push_exp(des_a, 1'b0);
        send(des_a, 1'b0, "t1");
        check("t1_pend_ready", 64'(o_ready), 64'(0));
        check("t1_pend_idx", 64'(o_des_seq_idx), 64'(0));
        @(negedge iclk);
        expect_frame(des_a, 1'b0, "t1");
        check("t1_idle_idx", 64'(o_des_seq_idx), 64'(0));
        check("t1_idle_busy", 64'(o_busy), 64'(0));
        check("t1_idle_ready", 64'(o_ready), 64'(1));
        check("t1_queue_empty", 64'(exp_q.size()), 64'(0));

        // T2: second descriptor loaded while the first streams.
        push_exp(des_a2, 1'b0);
        send(des_a2, 1'b0, "t2a");
        check("t2_pend_ready", 64'(o_ready), 64'(0));
        @(negedge iclk);
        check("t2_first_idx", 64'(o_des_seq_idx), 64'(1));
        check("t2_drained_ready", 64'(o_ready), 64'(1));
        push_exp(des_b, 1'b1);
        send(des_b, 1'b1, "t2b");
        check("t2_b_pend_ready", 64'(o_ready), 64'(0));
        repeat (30) @(negedge iclk);
        check("t2_idx_last", 64'(o_des_seq_idx), 64'(NUM_CHUNKS));
        check("t2_ready_stream", 64'(o_ready), 64'(0));
        @(negedge iclk);
        check("t2_tail0_ready", 64'(o_ready), 64'(0));
        @(negedge iclk);
        check("t2_tail1_idx", 64'(o_des_seq_idx), 64'(NUM_CHUNKS + 1));
        check("t2_tail1_ready", 64'(o_ready), 64'(0));
        check("t2_tail1_sw", 64'(o_des_sw), 64'(0));
        @(negedge iclk);
        exp_frames++;
        check("t2_a_frame_cnt", 64'(o_frame_cnt), 64'(exp_frames));
        check("t2_boundary_idx", 64'(o_des_seq_idx), 64'(1));
        check("t2_boundary_sw", 64'(o_des_sw), 64'(1));
        check("t2_boundary_ready", 64'(o_ready), 64'(1));
        expect_frame(des_b, 1'b1, "t2b");
        check("t2_idle_idx", 64'(o_des_seq_idx), 64'(0));

        // T3: pending held back by advance low.
        i_advance = 1'b0;
        push_exp(des_c, 1'b0);
        send(des_c, 1'b0, "t3");
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_idx", 64'(o_des_seq_idx), 64'(0));
            check("t3_hold_ready", 64'(o_ready), 64'(0));
            @(negedge iclk);
        end
        i_advance = 1'b1;
        @(negedge iclk);
        expect_frame(des_c, 1'b0, "t3");
        check("t3_idle_idx", 64'(o_des_seq_idx), 64'(0));

        // T4: reset mid-frame with a descriptor buffered.
        push_exp(des_d, 1'b1);
        send(des_d, 1'b1, "t4d");
        @(negedge iclk);
        send(des_e, 1'b0, "t4e");
        repeat (15) @(negedge iclk);
        check("t4_idx_before_rst", 64'(o_des_seq_idx), 64'(17));
        check("t4_ready_before_rst", 64'(o_ready), 64'(0));
        irst = 1'b1;
        @(negedge iclk);
        exp_q.delete();
        exp_frames = 16'd0;
        check("t4_rst_ready", 64'(o_ready), 64'(1));
        check("t4_rst_des", 64'(o_Des), 64'(0));
        check("t4_rst_idx", 64'(o_des_seq_idx), 64'(0));
        check("t4_rst_sw", 64'(o_des_sw), 64'(0));
        check("t4_rst_busy", 64'(o_busy), 64'(0));
        check("t4_rst_frame_cnt", 64'(o_frame_cnt), 64'(0));
        irst = 1'b0;
        @(negedge iclk);
        check("t4_dropped_idx0", 64'(o_des_seq_idx), 64'(0));
        @(negedge iclk);
        check("t4_dropped_idx1", 64'(o_des_seq_idx), 64'(0));
        push_exp(des_f, 1'b1);
        send(des_f, 1'b1, "t4f");
        @(negedge iclk);
        expect_frame(des_f, 1'b1, "t4f");

        // T5: valid held with changing data while not ready.
        i_advance = 1'b0;
        push_exp(des_g, 1'b0);
        send(des_g, 1'b0, "t5");
        for (int i = 0; i < 5; i++) begin
            i_des_valid = 1'b1;
            i_des       = make_des(8'(i) + 8'h70, $urandom);
            i_des_sw    = 1'b1;
            @(negedge iclk);
            check("t5_busy_ready", 64'(o_ready), 64'(0));
        end
        i_des_valid = 1'b0;
        i_advance   = 1'b1;
        @(negedge iclk);
        expect_frame(des_g, 1'b0, "t5");
        repeat (3) begin
            check("t5_no_extra_idx", 64'(o_des_seq_idx), 64'(0));
            @(negedge iclk);
        end
        check("t5_queue_empty", 64'(exp_q.size()), 64'(0));

        // T6: frame counter wrap.
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge iclk);
        check("t6_forced", 64'(o_frame_cnt), 64'(16'hFFFF));
        release dut.frame_cnt_q;
        @(negedge iclk);
        check("t6_released", 64'(o_frame_cnt), 64'(16'hFFFF));
        exp_frames = 16'hFFFF;
        push_exp(des_h, 1'b0);
        send(des_h, 1'b0, "t6");
        @(negedge iclk);
        expect_frame(des_h, 1'b0, "t6");
        check("t6_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
